sync_clk_slow_to_fast_clap: RTL and testbench



---
 rtl/sync_clk_slow_to_fast_clap_if.sv | 26 ++
 rtl/sync_clk_slow_to_fast_clap.sv | 50 +++++
 tb/tb_sync_clk_slow_to_fast_clap.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sync_clk_slow_to_fast_clap_if.sv
// Bundle for a single-bit slow-to-fast control crossing.
// The source drives signal_in (a level from the slow domain). The receiver
// returns the synchronized level and a one-cycle edge pulse. There is no
// valid/ready handshake: signal_in is a free-running level that must hold each
// phase long enough to be sampled, and signal_out is a fire-and-forget pulse
// with no back-pressure.
`timescale 1ns/1ps
interface sync_clk_slow_to_fast_clap_if;
  logic signal_in;
  logic signal_sync;
  logic signal_out;

  // Slow-domain side: drives the level and may observe the results.
  modport master (
    output signal_in,
    input  signal_sync,
    input  signal_out
  );

  // Fast-domain synchronizer side.
  modport slave (
    input  signal_in,
    output signal_sync,
    output signal_out
  );
endinterface

// File: rtl/sync_clk_slow_to_fast_clap.sv
// Slow-to-fast single-bit synchronizer with edge-pulse decode.
// signal_in goes straight into the first flop of an SYNC_STAGES-deep chain with
// no logic in front of it. A history flop d holds the previous value of the
// last stage, and the pulse is decoded from flop outputs only.
// SYNC_STAGES legal range is 2..4. EDGE_SEL selects the pulse source:
// 0 = rising, 1 = falling, 2 = both edges.
`timescale 1ns/1ps
module sync_clk_slow_to_fast_clap #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_SEL    = 0
) (
  input  logic                          clk_fast,
  input  logic                          rst,
  sync_clk_slow_to_fast_clap_if.slave   bus
);

  logic [SYNC_STAGES-1:0] s;
  logic                   d;
  logic                   s_last;
  logic                   edge_pulse;

  assign s_last = s[SYNC_STAGES-1];

  // Synchronizer chain plus history flop. An async clear drops the pulse at
  // once. Because d is cleared too, a high input at release shows up as a
  // rising edge.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      s <= '0;
      d <= 1'b0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], bus.signal_in};
      d <= s_last;
    end
  end

  // Edge decode from the last stage against its one-cycle-old copy.
  always_comb begin
    edge_pulse = 1'b0;
    case (EDGE_SEL)
      0:       edge_pulse = s_last & ~d;
      1:       edge_pulse = ~s_last & d;
      default: edge_pulse = s_last ^ d;
    endcase
  end

  assign bus.signal_sync = s_last;
  assign bus.signal_out  = edge_pulse;

endmodule

// File: tb/tb_sync_clk_slow_to_fast_clap.sv
// Directed bench for sync_clk_slow_to_fast_clap.
// Four instances share one input and one reset:
//   bit0 r2 (2 stages, rising), bit1 f2 (2 stages, falling),
//   bit2 b2 (2 stages, both edges), bit3 r3 (3 stages, rising).
// Each scenario starts on a negedge that is used as time 0. clk_fast rises at
// +5, +15, and so on. Outputs are sampled on negedges, midway between rising
// edges, so a pulse from 75 to 85 shows as a single high sample at 80.
`timescale 1ns/1ps
module tb_sync_clk_slow_to_fast_clap;

  logic clk_fast;
  logic rst;
  logic sig_in;
  int   n_cmp;
  int   n_bad;

  sync_clk_slow_to_fast_clap_if if_r2 ();
  sync_clk_slow_to_fast_clap_if if_f2 ();
  sync_clk_slow_to_fast_clap_if if_b2 ();
  sync_clk_slow_to_fast_clap_if if_r3 ();

  assign if_r2.signal_in = sig_in;
  assign if_f2.signal_in = sig_in;
  assign if_b2.signal_in = sig_in;
  assign if_r3.signal_in = sig_in;

  sync_clk_slow_to_fast_clap #(.SYNC_STAGES(2), .EDGE_SEL(0)) u_r2 (.clk_fast(clk_fast), .rst(rst), .bus(if_r2));
  sync_clk_slow_to_fast_clap #(.SYNC_STAGES(2), .EDGE_SEL(1)) u_f2 (.clk_fast(clk_fast), .rst(rst), .bus(if_f2));
  sync_clk_slow_to_fast_clap #(.SYNC_STAGES(2), .EDGE_SEL(2)) u_b2 (.clk_fast(clk_fast), .rst(rst), .bus(if_b2));
  sync_clk_slow_to_fast_clap #(.SYNC_STAGES(3), .EDGE_SEL(0)) u_r3 (.clk_fast(clk_fast), .rst(rst), .bus(if_r3));

  logic [3:0] outs;
  logic [3:0] syncs;
  assign outs  = {if_r3.signal_out,  if_b2.signal_out,  if_f2.signal_out,  if_r2.signal_out};
  assign syncs = {if_r3.signal_sync, if_b2.signal_sync, if_f2.signal_sync, if_r2.signal_sync};

  // Clock and initial reset
  initial begin
    clk_fast = 1'b0;
    forever #5 clk_fast = ~clk_fast;
  end

  // Driver: align to a negedge, assert reset and clear the input.
  task automatic begin_scenario();
    @(negedge clk_fast);
    rst    = 1'b1;
    sig_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_v;
    begin_scenario();
    #1;
    n_cmp++;
    if (outs !== 4'b0000 || syncs !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_async out=%b sync=%b exp=0000/0000", outs, syncs);
    end
    for (int t = 10; t <= 60; t += 10) begin
      @(negedge clk_fast);
      if (t == 20) rst = 1'b0;
      exp_v = 4'b0000;
      n_cmp++;
      if (outs !== exp_v || syncs !== exp_v) begin
        n_bad++;
        $display("FAIL reset_idle t=%0d out=%b sync=%b exp=%b/%b", t, outs, syncs, exp_v, exp_v);
      end
    end
  endtask

  task automatic test_edges();
    logic [3:0] exp_out;
    logic [3:0] exp_sync;
    begin_scenario();
    for (int t = 10; t <= 200; t += 10) begin
      @(negedge clk_fast);
      if (t == 20)  rst    = 1'b0;
      if (t == 60)  sig_in = 1'b1;
      if (t == 100) sig_in = 1'b0;
      exp_out  = {t == 90, (t == 80) || (t == 120), t == 120, t == 80};
      exp_sync = {(t >= 90) && (t <= 120), {3{(t >= 80) && (t <= 110)}}};
      n_cmp++;
      if (outs !== exp_out) begin
        n_bad++;
        $display("FAIL edges_out t=%0d got=%b exp=%b", t, outs, exp_out);
      end
      n_cmp++;
      if (syncs !== exp_sync) begin
        n_bad++;
        $display("FAIL edges_sync t=%0d got=%b exp=%b", t, syncs, exp_sync);
      end
      if (t == 60 || t == 70) begin
        n_cmp++;
        if (u_r2.s[0] !== (t == 70)) begin
          n_bad++;
          $display("FAIL edges_s0 t=%0d got=%b exp=%b", t, u_r2.s[0], (t == 70));
        end
      end
    end
  endtask

  task automatic test_release_high();
    logic [3:0] exp_out;
    logic [3:0] exp_sync;
    begin_scenario();
    for (int t = 10; t <= 120; t += 10) begin
      @(negedge clk_fast);
      if (t == 10) sig_in = 1'b1;
      if (t == 20) rst    = 1'b0;
      exp_out  = {t == 50, t == 40, 1'b0, t == 40};
      exp_sync = {t >= 50, {3{t >= 40}}};
      n_cmp++;
      if (outs !== exp_out) begin
        n_bad++;
        $display("FAIL release_out t=%0d got=%b exp=%b", t, outs, exp_out);
      end
      n_cmp++;
      if (syncs !== exp_sync) begin
        n_bad++;
        $display("FAIL release_sync t=%0d got=%b exp=%b", t, syncs, exp_sync);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    begin_scenario();
    for (int t = 10; t <= 200; t += 10) begin
      @(negedge clk_fast);
      if (t == 20)  rst    = 1'b0;
      if (t == 60)  sig_in = 1'b1;
      if (t == 100) sig_in = 1'b0;
      if (t == 110) rst    = 1'b0;
      if (t == 70) begin
        #6;
        n_cmp++;
        if (outs !== 4'b0101) begin
          n_bad++;
          $display("FAIL midrst_pre t=76 got=%b exp=0101", outs);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (outs !== 4'b0000 || syncs !== 4'b0000) begin
          n_bad++;
          $display("FAIL midrst_async t=79 out=%b sync=%b exp=0000/0000", outs, syncs);
        end
      end
      if (t >= 80) begin
        n_cmp++;
        if (outs !== 4'b0000 || syncs !== 4'b0000) begin
          n_bad++;
          $display("FAIL midrst_after t=%0d out=%b sync=%b exp=0000/0000", t, outs, syncs);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_out;
    begin_scenario();
    for (int t = 10; t <= 200; t += 10) begin
      @(negedge clk_fast);
      if (t == 20)  rst    = 1'b0;
      if (t == 60)  sig_in = 1'b1;
      if (t == 90)  sig_in = 1'b0;
      if (t == 120) sig_in = 1'b1;
      if (t == 150) sig_in = 1'b0;
      exp_out = {(t == 90) || (t == 150),
                 (t == 80) || (t == 110) || (t == 140) || (t == 170),
                 (t == 110) || (t == 170),
                 (t == 80) || (t == 140)};
      n_cmp++;
      if (outs !== exp_out) begin
        n_bad++;
        $display("FAIL b2b_out t=%0d got=%b exp=%b", t, outs, exp_out);
      end
    end
  endtask

  // Sequencer and final report
  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    sig_in = 1'b0;
    test_reset();
    test_edges();
    test_release_high();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
